dcpu_mem_responder: RTL and testbench

Bus responder (memory side) for the dcpu memory interface. It accepts chip-select requests from the CPU. It then serves reads and writes from a 2^AW-word on-chip RAM after a configurable number of wait states, and returns a one-cycle acknowledge with read data. It sits between the CPU bus port and the RAM, and replaces a zero-latency ideal memory.

---
 rtl/dcpu_pkg.sv | 14 +
 rtl/dcpu_spram.sv | 48 ++++
 rtl/dcpu_mem_responder.sv | 136 +++++++++++++
 tb/tb_dcpu_mem_responder.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dcpu_pkg.sv
// Definitions shared between the dcpu CPU and its memory responder:
// bus width, wait-counter width and responder FSM states.
package dcpu_pkg;

  localparam int DCPU_W     = 16;
  localparam int DCPU_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } dcpu_state_e;

endpackage

// File: rtl/dcpu_spram.sv
// Single-port synchronous RAM, 2^AW x W, with a registered read port that
// holds its value unless a read or a clear is strobed.
module dcpu_spram
  import dcpu_pkg::*;
#(
  parameter int W  = DCPU_W,
  parameter int AW = 12
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_wr,
  input  logic          i_rd,
  input  logic          i_clr,
  input  logic [AW-1:0] i_addr,
  input  logic [W-1:0]  i_wdat,
  output logic [W-1:0]  o_rdat
);

  // Array contents are intentionally left untouched by reset.
  logic [W-1:0] mem [2**AW];
  logic [W-1:0] rdat_d, rdat_q;

  always_ff @(posedge i_clk) begin
    if (i_wr) begin
      mem[i_addr] <= i_wdat;
    end
  end

  always_comb begin
    rdat_d = rdat_q;
    if (i_clr) begin
      rdat_d = '0;
    end else if (i_rd) begin
      rdat_d = mem[i_addr];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rdat_q <= '0;
    end else begin
      rdat_q <= rdat_d;
    end
  end

  assign o_rdat = rdat_q;

endmodule

// File: rtl/dcpu_mem_responder.sv
// Memory-side responder for the dcpu bus: latches a request, waits WAIT cycles,
// then accesses the on-chip RAM and acks for one cycle. Optional write
// protection of the low ROM_WORDS words is enabled by DCPU_MEM_WPROT_EN.
module dcpu_mem_responder
  import dcpu_pkg::*;
#(
  parameter int W    = DCPU_W,
  parameter int AW   = 12,
  parameter int WAIT = 1
`ifdef DCPU_MEM_WPROT_EN
  ,
  parameter int ROM_WORDS = 256
`endif
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_cs,
  input  logic         i_we,
  input  logic [W-1:0] i_addr,
  input  logic [W-1:0] i_dat,
  output logic [W-1:0] o_dat,
  output logic         o_ack,
  output logic         o_err
);

  localparam logic [DCPU_CNT_W-1:0] WAIT_LD = WAIT[DCPU_CNT_W-1:0];

  dcpu_state_e           state_q, state_d;
  logic [DCPU_CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]          addr_q, addr_d;
  logic [W-1:0]          wdat_q, wdat_d;
  logic                  we_q, we_d;
  logic                  ack_q, ack_d;
  logic                  err_q, err_d;

  logic acc;
  logic oor;
  logic prot;
  logic ram_wr, ram_rd, ram_clr;

  // The access uses the *_d view so that WAIT=0 can latch and access on one edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    we_d    = we_q;
    acc     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_cs) begin
          addr_d = i_addr;
          we_d   = i_we;
          wdat_d = i_dat;
          cnt_d  = WAIT_LD;
          if (WAIT_LD == '0) begin
            state_d = ST_ACK;
            acc     = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (!i_cs) begin
          state_d = ST_IDLE;
        end else if (cnt_q <= DCPU_CNT_W'(1)) begin
          state_d = ST_ACK;
          acc     = 1'b1;
        end else begin
          cnt_d = DCPU_CNT_W'(cnt_q - 1);
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    oor = (addr_d >> AW) != '0;
`ifdef DCPU_MEM_WPROT_EN
    prot = we_d && (addr_d < W'(ROM_WORDS));
`else
    prot = 1'b0;
`endif

    // Reset on the access edge must not let a pending write reach the array.
    ram_wr  = acc && !i_reset && we_d && !oor && !prot;
    ram_rd  = acc && !i_reset && !we_d && !oor;
    ram_clr = acc && !i_reset && !we_d && oor;

    ack_d = acc;
    err_d = acc && (oor || prot);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdat_q  <= '0;
      we_q    <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      we_q    <= we_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  dcpu_spram #(
    .W  (W),
    .AW (AW)
  ) u_ram (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_wr    (ram_wr),
    .i_rd    (ram_rd),
    .i_clr   (ram_clr),
    .i_addr  (addr_d[AW-1:0]),
    .i_wdat  (wdat_d),
    .o_rdat  (o_dat)
  );

  assign o_ack = ack_q;
  assign o_err = err_q;

endmodule

// File: tb/tb_dcpu_mem_responder.sv
// Scoreboard bench for dcpu_mem_responder: three instances (WAIT = 0, 1, 3)
// driven by directed and random requests, checked against a word-level memory model.
module tb_dcpu_mem_responder;

  localparam int NDUT = 3;
  localparam int WAITS [NDUT] = '{0, 1, 3};
  localparam int TO = 40;

  typedef struct {
    int          cyc;
    logic [15:0] dat;
    bit          dat_chk;
    bit          err;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst  [NDUT];
  logic        cs   [NDUT];
  logic        we   [NDUT];
  logic [15:0] addr [NDUT];
  logic [15:0] din  [NDUT];
  logic [15:0] dout [NDUT];
  logic        ack  [NDUT];
  logic        err  [NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    dcpu_mem_responder #(
      .W    (16),
      .AW   (12),
      .WAIT (WAITS[g])
    ) u_dut (
      .i_clk   (clk),
      .i_reset (rst[g]),
      .i_cs    (cs[g]),
      .i_we    (we[g]),
      .i_addr  (addr[g]),
      .i_dat   (din[g]),
      .o_dat   (dout[g]),
      .o_ack   (ack[g]),
      .o_err   (err[g])
    );
  end

  // Reference model: per-instance word memory keyed by k*65536+addr.
  logic [15:0] mem_m [int];
  logic [15:0] last_dat [NDUT];
  bit          last_ok  [NDUT];
  exp_t        sb_q [NDUT][$];

  int checks   = 0;
  int failures = 0;

  function automatic exp_t predict(int k, bit w, logic [15:0] a, logic [15:0] d, int n);
    exp_t e;
    int   key;
    bit   oor;
    bit   prot;
    key  = k * 65536 + int'(a);
    oor  = (a >= 16'h1000);
    prot = 1'b0;
`ifdef DCPU_MEM_WPROT_EN
    prot = w && (a < 16'd256);
`endif
    e.cyc = n + WAITS[k] + 1;
    e.err = oor || prot;
    if (w) begin
      e.dat     = last_dat[k];
      e.dat_chk = last_ok[k];
      if (!oor && !prot) mem_m[key] = d;
    end else if (oor) begin
      e.dat     = 16'h0000;
      e.dat_chk = 1'b1;
    end else begin
      e.dat_chk = mem_m.exists(key);
      e.dat     = e.dat_chk ? mem_m[key] : 16'h0000;
    end
    if (!w) begin
      last_dat[k] = e.dat;
      last_ok[k]  = e.dat_chk;
    end
    return e;
  endfunction

  task automatic chk(string nm, int k, int got, int want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s dut%0d cyc=%0d got=0x%0h want=0x%0h", nm, k, cyc, got, want);
    end
  endtask

  // Monitor: pops one expectation per observed acknowledge.
  always @(negedge clk) begin
    exp_t e;
    for (int k = 0; k < NDUT; k++) begin
      if (ack[k] === 1'b1) begin
        if (sb_q[k].size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_ack dut%0d cyc=%0d got ack=1 want ack=0", k, cyc);
        end else begin
          e = sb_q[k].pop_front();
          chk("ack_cycle", k, cyc, e.cyc);
          chk("err", k, int'(err[k]), int'(e.err));
          if (e.dat_chk) chk("rdata", k, int'(dout[k]), int'(e.dat));
        end
      end else if (err[k] === 1'b1) begin
        checks++;
        failures++;
        $display("FAIL err_without_ack dut%0d cyc=%0d got err=1 want err=0", k, cyc);
      end
    end
  end

  // Presents a request; b2b means we are in the ACK cycle of the previous one.
  task automatic issue(int k, bit w, logic [15:0] a, logic [15:0] d, bit b2b);
    int n;
    bit got;
    n   = b2b ? cyc + 1 : cyc;
    got = 1'b0;
    cs[k]   = 1'b1;
    we[k]   = w;
    addr[k] = a;
    din[k]  = d;
    sb_q[k].push_back(predict(k, w, a, d, n));
    for (int t = 0; t < TO && !got; t++) begin
      @(negedge clk);
      if (ack[k] === 1'b1) begin
        got = 1'b1;
      end else if (cyc > n) begin
        we[k]   = 1'($urandom);
        addr[k] = 16'($urandom);
        din[k]  = 16'($urandom);
      end
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL ack_timeout dut%0d cyc=%0d got no ack want ack within %0d", k, cyc, TO);
    end
  endtask

  task automatic release_cs(int k);
    cs[k]   = 1'b0;
    we[k]   = 1'b0;
    addr[k] = 16'($urandom);
    @(negedge clk);
  endtask

  task automatic abort_wr(int k, logic [15:0] a, logic [15:0] d);
    cs[k]   = 1'b1;
    we[k]   = 1'b1;
    addr[k] = a;
    din[k]  = d;
    @(negedge clk);
    @(negedge clk);
    cs[k] = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  // Write whose reset lands one cycle after the request is latched.
  task automatic reset_mid(int k, logic [15:0] a, logic [15:0] d);
    cs[k]   = 1'b1;
    we[k]   = 1'b1;
    addr[k] = a;
    din[k]  = d;
    if (WAITS[k] == 0) sb_q[k].push_back(predict(k, 1'b1, a, d, cyc));
    @(negedge clk);
    rst[k] = 1'b1;
    @(negedge clk);
    chk("rst_mid_ack", k, int'(ack[k]), 0);
    chk("rst_mid_dat", k, int'(dout[k]), 0);
    chk("rst_mid_err", k, int'(err[k]), 0);
    rst[k] = 1'b0;
    cs[k]  = 1'b0;
    last_dat[k] = 16'h0000;
    last_ok[k]  = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    for (int k = 0; k < NDUT; k++) begin
      rst[k] = 1'b1; cs[k] = 1'b0; we[k] = 1'b0;
      addr[k] = 16'h0000; din[k] = 16'h0000;
      last_dat[k] = 16'h0000; last_ok[k] = 1'b1;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < NDUT; k++) begin
      chk("reset_ack", k, int'(ack[k]), 0);
      chk("reset_err", k, int'(err[k]), 0);
      chk("reset_dat", k, int'(dout[k]), 0);
      rst[k] = 1'b0;
    end
    @(negedge clk);

    // WAIT=0: read after write, out of range, write protect, reset in ACK
    issue(0, 1'b1, 16'h0010, 16'h1234, 1'b0); release_cs(0);
    issue(0, 1'b0, 16'h0010, 16'h0000, 1'b0); release_cs(0);
    issue(0, 1'b1, 16'h0000, 16'h0ABC, 1'b0); release_cs(0);
    issue(0, 1'b0, 16'h1000, 16'h0000, 1'b0); release_cs(0);
    issue(0, 1'b1, 16'h1000, 16'h5555, 1'b0); release_cs(0);
    issue(0, 1'b0, 16'h0000, 16'h0000, 1'b0); release_cs(0);
    issue(0, 1'b1, 16'h0005, 16'h7777, 1'b0); release_cs(0);
    issue(0, 1'b0, 16'h0005, 16'h0000, 1'b0); release_cs(0);
    issue(0, 1'b1, 16'h0040, 16'h0101, 1'b0); release_cs(0);
    reset_mid(0, 16'h0040, 16'hC0DE);
    issue(0, 1'b0, 16'h0040, 16'h0000, 1'b0); release_cs(0);

    // WAIT=1: back-to-back reads, reset during WAIT drops the write
    issue(1, 1'b1, 16'h0001, 16'h1111, 1'b0); release_cs(1);
    issue(1, 1'b1, 16'h0002, 16'h2222, 1'b0); release_cs(1);
    issue(1, 1'b0, 16'h0001, 16'h0000, 1'b0);
    issue(1, 1'b0, 16'h0002, 16'h0000, 1'b1); release_cs(1);
    issue(1, 1'b1, 16'h0050, 16'h5050, 1'b0); release_cs(1);
    reset_mid(1, 16'h0050, 16'hDEAD);
    issue(1, 1'b0, 16'h0050, 16'h0000, 1'b0); release_cs(1);

    // WAIT=3: wait states, abort
    issue(2, 1'b1, 16'h0020, 16'hBEEF, 1'b0); release_cs(2);
    issue(2, 1'b0, 16'h0020, 16'h0000, 1'b0); release_cs(2);
    issue(2, 1'b1, 16'h0030, 16'h0000, 1'b0); release_cs(2);
    abort_wr(2, 16'h0030, 16'hAAAA);
    issue(2, 1'b0, 16'h0030, 16'h0000, 1'b0); release_cs(2);

    // Random traffic: mixed address classes, random back-to-back holds
    for (int k = 0; k < NDUT; k++) begin
      bit          held;
      logic [15:0] a;
      held = 1'b0;
      for (int i = 0; i < 80; i++) begin
        case ($urandom_range(0, 5))
          0, 1, 2: a = 16'($urandom_range(0, 15));
          3:       a = 16'h0FF0 + 16'($urandom_range(0, 15));
          4:       a = 16'h00F8 + 16'($urandom_range(0, 15));
          default: a = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'h1000 + 16'($urandom_range(0, 15));
        endcase
        issue(k, 1'($urandom), a, 16'($urandom), held);
        if ($urandom_range(0, 1) == 1) begin
          held = 1'b1;
        end else begin
          release_cs(k);
          held = 1'b0;
        end
      end
      if (held) release_cs(k);
    end

    repeat (5) @(negedge clk);
    for (int k = 0; k < NDUT; k++) chk("sb_empty", k, sb_q[k].size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
